bcd_xs3_serial_conv: RTL and testbench
======================================

# bcd_xs3_serial_conv

Parametrised, sequential BCD↔Excess-3 code converter for multi-digit words. It accepts a DIGITS-wide packed word over a valid/ready handshake and converts one 4-bit digit per clock, LSB digit first. Direction is selected per word. Invalid source digits are flagged per digit. The block sits between a BCD datapath (counters, display drivers) and any Excess-3 arithmetic or self-complementing logic, and generalises the single-digit combinational converter.

## Interface
- DIGITS, 4, number of 4-bit digits per word; legal range ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  source word present.
- in_ready  out  1  block can accept a word; equals (state==IDLE) && rst_n.
- in_data  in  4*DIGITS  packed source digits; digit i is bits [4i+3:4i].
- in_mode  in  1  0 = BCD→XS3, 1 = XS3→BCD; sampled only at acceptance.
- out_valid  out  1  converted word available.
- out_ready  in  1  sink accepts the word.
- out_data  out  4*DIGITS  converted digits, same packing as in_data.
- out_err_mask  out  DIGITS  bit i set when source digit i was invalid.
- out_err  out  1  OR-reduction of out_err_mask.

## Operation
- The FSM has three states: IDLE, CONV, and DONE.
- IDLE: in_ready=1. When in_valid && in_ready at a clock edge, latch in_data and in_mode, clear the result and error registers, set digit counter to 0, and go to CONV.
- CONV: each cycle convert digit[cnt] into result[cnt] and err[cnt], then increment cnt. After digit DIGITS-1, go to DONE.
- DONE: out_valid=1. out_data, out_err_mask, and out_err stay stable until out_valid && out_ready at an edge, then go to IDLE.
- BCD→XS3: source 0–9 maps to source+3, giving 3–12. Source 10–15 is invalid: the result digit is 4'h0 and the err bit is set.
- XS3→BCD: source 3–12 maps to source−3, giving 0–9. Source 0–2 and 13–15 are invalid: the result digit is 4'h0 and the err bit is set.
- All arithmetic is 4-bit per digit. There is no carry between digits.
- in_data, in_mode, and in_valid are ignored outside IDLE. Changing them mid-conversion has no effect.
- out_ready is ignored when out_valid=0.
- The digit counter is $clog2(DIGITS) bits, minimum 1. DIGITS=1 converts in a single CONV cycle.
- Reset (async, any state, including mid-CONV or DONE):
  - state=IDLE, out_valid=0, out_data=0, out_err_mask=0, out_err=0, counter=0.
  - in_ready=0 while rst_n=0 and 1 from deassertion.
  - Any in-flight word is discarded without output.

## Timing
- Acceptance edge T0: in_ready falls after T0.
- Digit i is written at edge T0+1+i.
- out_valid rises after edge T0+DIGITS, so latency is DIGITS cycles from acceptance to out_valid.
- If out_ready is high when out_valid rises, the output handshake completes at edge T0+DIGITS+1. out_valid falls and in_ready rises after that edge.
- The next acceptance is possible at T0+DIGITS+2, so peak throughput is one word per DIGITS+2 cycles.
- Backpressure: out_valid and all outputs hold indefinitely while out_ready=0. in_ready stays 0.
- out_data and the error outputs change only at the acceptance edge (cleared) and during CONV edges. They are fully valid whenever out_valid=1.

## Test plan
- **Reset and idle.** Hold rst_n=0 for 3 cycles, then release. Required: all outputs are 0 during reset, and in_ready=1 after release.
- **BCD→XS3, DIGITS=4.** Send in_data=16'h1947, in_mode=0, out_ready=1. Required: out_valid 4 cycles after acceptance, out_data=16'h4C7A, out_err_mask=4'b0000. Also sweep every single-digit value 0–9 through digit 0 and check against source+3.
- **XS3→BCD.** Send in_data=16'h4C7A, in_mode=1. Required: out_data=16'h1947, out_err=0. Send 16'h3333. Required: 16'h0000.
- **Invalid digits.** Send in_data=16'h12A4, mode 0. Required: out_data=16'h4507, out_err_mask=4'b0010, out_err=1. Send 16'hD2C0, mode 1. Required: out_data=16'h0090, out_err_mask=4'b1101.
- **Backpressure and input stability.** Hold out_ready=0 for 10 cycles after out_valid, toggling in_data and in_mode throughout. Required: outputs frozen, in_ready=0, and exactly one word delivered after out_ready=1. A back-to-back stream with both valids high gives out_valid pulses every 6 cycles.
- **Reset mid-operation.** Pulse rst_n=0 for 1 cycle during CONV, after 2 digits. Required: outputs clear immediately, no out_valid for that word, and the next word 16'h0000 in mode 0 yields 16'h3333.

Source files
------------

// File: rtl/bcd_xs3_serial_conv.sv
// Serial multi-digit BCD <-> Excess-3 converter: one 4-bit digit per clock, LSB digit first.
// A word is accepted on a valid/ready handshake and held at the output until the sink takes it.
module bcd_xs3_serial_conv #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic [DIGITS-1:0]   out_err_mask,
  output logic                out_err
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = 4 * DIGITS;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [W-1:0]  src_reg, src_next;
  logic          mode_reg, mode_next;
  logic [W-1:0]  result_reg, result_next;
  logic [DIGITS-1:0] err_reg, err_next;

  logic [3:0] cur_src;
  logic [3:0] conv_digit;
  logic       conv_err;

  // Single-digit converter applied to the digit currently selected by the counter.
  always_comb begin
    cur_src    = src_reg[4*cnt_reg +: 4];
    conv_digit = 4'h0;
    conv_err   = 1'b0;
    if (!mode_reg) begin
      if (cur_src <= 4'd9) begin
        conv_digit = cur_src + 4'd3;
      end else begin
        conv_err = 1'b1;
      end
    end else begin
      if ((cur_src >= 4'd3) && (cur_src <= 4'd12)) begin
        conv_digit = cur_src - 4'd3;
      end else begin
        conv_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    src_next    = src_reg;
    mode_next   = mode_reg;
    result_next = result_reg;
    err_next    = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          src_next    = in_data;
          mode_next   = in_mode;
          result_next = '0;
          err_next    = '0;
          cnt_next    = '0;
          state_next  = CONV;
        end
      end
      CONV: begin
        result_next[4*cnt_reg +: 4] = conv_digit;
        err_next[cnt_reg]           = conv_err;
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      src_reg    <= '0;
      mode_reg   <= 1'b0;
      result_reg <= '0;
      err_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      src_reg    <= src_next;
      mode_reg   <= mode_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  // Gating with rst_n keeps in_ready low for the whole time reset is asserted.
  assign in_ready     = (state_reg == IDLE) && rst_n;
  assign out_valid    = (state_reg == DONE);
  assign out_data     = result_reg;
  assign out_err_mask = err_reg;
  assign out_err      = |err_reg;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Directed bench for bcd_xs3_serial_conv (DIGITS=4): conversion vectors, error flags,
// backpressure, back-to-back throughput and reset in the middle of a conversion.
`timescale 1ns/1ps
module tb_bcd_xs3_serial_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_err_mask;
  logic        out_err;

  int total = 0;
  int bad   = 0;
  int hs_count = 0;

  bcd_xs3_serial_conv #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_count++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Accept one word, measure latency, check the converted outputs, optionally complete handshake.
  task automatic send_word(input string tag, input logic [15:0] d, input logic m,
                           input logic [15:0] ed, input logic [3:0] em);
    int lat;
    @(negedge clk);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'd4);
    check_val({tag, "_data"}, 32'(out_data), 32'(ed));
    check_val({tag, "_mask"}, 32'(out_err_mask), 32'(em));
    check_val({tag, "_err"}, 32'(out_err), 32'(em != 4'b0000));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check_val({tag, "_vdrop"}, 32'(out_valid), 32'd0);
      check_val({tag, "_rdyback"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int rises[3];
    int nrise;
    int hs0;
    logic prev_v;
    logic seen;
    logic [15:0] word;
    logic [15:0] expw;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_mode   = 1'b0;
    out_ready = 1'b1;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(in_ready), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    check_val("rst_mask", 32'(out_err_mask), 32'd0);
    check_val("rst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("idle_ready", 32'(in_ready), 32'd1);

    // Conversion vectors
    send_word("b2x_1947", 16'h1947, 1'b0, 16'h4C7A, 4'b0000);
    for (int d = 0; d < 10; d++) begin
      word = 16'(d);
      expw = 16'h3330 | 16'(d + 3);
      send_word($sformatf("sweep_%0d", d), word, 1'b0, expw, 4'b0000);
    end
    send_word("x2b_4C7A", 16'h4C7A, 1'b1, 16'h1947, 4'b0000);
    send_word("x2b_3333", 16'h3333, 1'b1, 16'h0000, 4'b0000);
    send_word("inv_12A4", 16'h12A4, 1'b0, 16'h4507, 4'b0010);
    send_word("inv_D2C0", 16'hD2C0, 1'b1, 16'h0090, 4'b1101);

    // Backpressure with noisy inputs
    out_ready = 1'b0;
    send_word("bp", 16'h1947, 1'b0, 16'h4C7A, 4'b0000);
    hs0 = hs_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_data  = 16'($urandom);
      in_mode  = ~in_mode;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_val($sformatf("bp_data_%0d", i), 32'(out_data), 32'h4C7A);
      check_val($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
      check_val($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_release", 32'(out_valid), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check_val("bp_one_word", 32'(hs_count - hs0), 32'd1);

    // Back-to-back stream
    in_data  = 16'h0000;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    nrise    = 0;
    rises    = '{-100, -100, -100};
    prev_v   = out_valid;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && !prev_v && nrise < 3) begin
        rises[nrise] = i;
        nrise++;
        check_val($sformatf("stream_data_%0d", nrise), 32'(out_data), 32'h3333);
      end
      prev_v = out_valid;
    end
    check_val("stream_gap1", 32'(rises[1] - rises[0]), 32'd6);
    check_val("stream_gap2", 32'(rises[2] - rises[1]), 32'd6);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check_val("stream_drain", 32'(in_ready), 32'd1);

    // Reset in the middle of a conversion
    @(negedge clk);
    in_data  = 16'h1947;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("mid_partial", 32'(out_data), 32'h007A);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_data", 32'(out_data), 32'd0);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mid_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("mid_no_output", 32'(seen), 32'd0);
    send_word("mid_next", 16'h0000, 1'b0, 16'h3333, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
